// File: rtl/alu_exec_if.sv
// alu_exec_if -- operation/result bundle between the execute stage and alu_exec.
//
// Parameter: WIDTH  datapath width (must match the alu_exec instance).
//
// Signals (direction as seen by the unit, i.e. the slave modport):
//   Flush       in   abandon any in-flight divide
//   InValid     in   operation presented this cycle
//   InReady     out  unit can accept an operation
//   opb5        in   opcode bit 5 (1 = R-type)
//   funct3      in   instruction funct3
//   funct7b5    in   funct7 bit 5
//   funct7b0    in   funct7 bit 0 (M-extension select)
//   ALUOp       in   00 add, 01 sub, 10/11 decode by funct fields
//   SrcA, SrcB  in   operands
//   ALUControl  out  combinational decode of the current inputs
//   OutValid    out  one-cycle completion pulse
//   ALUResult   out  registered result, held until the next completion
//   Zero        out  registered ALUResult == 0
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             Flush;
    logic             InValid;
    logic             InReady;
    logic             opb5;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             funct7b0;
    logic [1:0]       ALUOp;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUControl;
    logic             OutValid;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;

    // Execute stage drives the operation and observes the result.
    modport master (
        output Flush, InValid, opb5, funct3, funct7b5, funct7b0, ALUOp, SrcA, SrcB,
        input  InReady, ALUControl, OutValid, ALUResult, Zero
    );

    // The execute unit itself.
    modport slave (
        input  Flush, InValid, opb5, funct3, funct7b5, funct7b0, ALUOp, SrcA, SrcB,
        output InReady, ALUControl, OutValid, ALUResult, Zero
    );
endinterface

// File: rtl/alu_exec.sv
// alu_exec -- execute unit: ALU decode, base RV integer ALU and, optionally,
// the RV M extension (single-cycle multiply, iterative restoring divide).
//
// Build option: define ALU_EXEC_MDU_EN to include the multiplier, the divide
// sequencer (IDLE/DIV/FIX) and M-op decode. Without it funct7b0 and Flush are
// ignored, InReady is tied high and every operation completes in one cycle.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high reset
//   bus    alu_exec_if.slave -- operation in, InReady/ALUControl/result out
//
// Timing: base ops, multiplies and divide fast paths (divisor 0, signed
// overflow) raise OutValid the cycle after acceptance. Other divides take
// WIDTH shift-subtract cycles plus one sign-fix cycle, InReady low meanwhile.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_exec_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    logic [3:0]       w_alu_control;
    logic [WIDTH-1:0] w_base_result;
    logic [SW-1:0]    w_shamt;
    logic             w_is_m;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_out_valid;

    assign w_shamt = bus.SrcB[SW-1:0];

`ifdef ALU_EXEC_MDU_EN
    assign w_is_m = bus.ALUOp[1] & bus.opb5 & bus.funct7b0;
`else
    assign w_is_m = 1'b0;
`endif

    // ALU operation decode; M ops report add (0000).
    always_comb begin
        w_alu_control = 4'b0000;
        case (bus.ALUOp)
            2'b00:   w_alu_control = 4'b0000;
            2'b01:   w_alu_control = 4'b0001;
            default: begin
                case (bus.funct3)
                    3'b000:  w_alu_control = (bus.opb5 & bus.funct7b5) ? 4'b0001 : 4'b0000;
                    3'b001:  w_alu_control = 4'b1000;
                    3'b010:  w_alu_control = 4'b0101;
                    3'b011:  w_alu_control = 4'b1001;
                    3'b100:  w_alu_control = 4'b0100;
                    3'b101:  w_alu_control = bus.funct7b5 ? 4'b0111 : 4'b0110;
                    3'b110:  w_alu_control = 4'b0011;
                    default: w_alu_control = 4'b0010;
                endcase
            end
        endcase
        if (w_is_m) begin
            w_alu_control = 4'b0000;
        end
    end

    assign bus.ALUControl = w_alu_control;

    always_comb begin
        w_base_result = '0;
        case (w_alu_control)
            4'b0000: w_base_result = bus.SrcA + bus.SrcB;
            4'b0001: w_base_result = bus.SrcA - bus.SrcB;
            4'b0010: w_base_result = bus.SrcA & bus.SrcB;
            4'b0011: w_base_result = bus.SrcA | bus.SrcB;
            4'b0100: w_base_result = bus.SrcA ^ bus.SrcB;
            4'b0101: w_base_result = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
            4'b0110: w_base_result = bus.SrcA >> w_shamt;
            4'b0111: w_base_result = $signed(bus.SrcA) >>> w_shamt;
            4'b1000: w_base_result = bus.SrcA << w_shamt;
            4'b1001: w_base_result = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
            default: w_base_result = '0;
        endcase
    end

`ifdef ALU_EXEC_MDU_EN
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_quo;      // dividend shifts out the top, quotient bits shift in
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_is_rem;
    logic [SW-1:0]    r_cnt;

    logic [2*WIDTH-1:0] w_ma, w_mb, w_prod;
    logic [WIDTH-1:0]   w_mdu_result, w_result_now;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_fix_result;
    logic [WIDTH:0]     w_shift_rem, w_trial;
    logic               w_is_div, w_div_signed, w_div_zero, w_div_ovf, w_div_fast;
    logic               w_a_neg, w_b_neg;

    assign w_is_div     = w_is_m & bus.funct3[2];
    assign w_div_signed = ~bus.funct3[0];
    assign w_div_zero   = (bus.SrcB == '0);
    assign w_div_ovf    = w_div_signed & (bus.SrcA == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.SrcB);
    assign w_div_fast   = w_div_zero | w_div_ovf;

    // Operands extended to 2*WIDTH so one unsigned multiply yields the correct
    // high word for mulh (s x s), mulhsu (s x u) and mulhu (u x u).
    assign w_ma   = {{WIDTH{(bus.funct3[1:0] != 2'b11) & bus.SrcA[WIDTH-1]}}, bus.SrcA};
    assign w_mb   = {{WIDTH{(bus.funct3[1:0] == 2'b01) & bus.SrcB[WIDTH-1]}}, bus.SrcB};
    assign w_prod = w_ma * w_mb;

    always_comb begin
        w_mdu_result = w_prod[2*WIDTH-1:WIDTH];
        if (bus.funct3 == 3'b000) begin
            w_mdu_result = w_prod[WIDTH-1:0];
        end else if (bus.funct3[2]) begin
            // Only reached for fast-path divides: divisor 0 or signed overflow.
            if (bus.funct3[1]) begin
                w_mdu_result = w_div_zero ? bus.SrcA : '0;
            end else begin
                w_mdu_result = w_div_zero ? '1 : bus.SrcA;
            end
        end
    end

    assign w_result_now = w_is_m ? w_mdu_result : w_base_result;

    assign w_a_neg = w_div_signed & bus.SrcA[WIDTH-1];
    assign w_b_neg = w_div_signed & bus.SrcB[WIDTH-1];
    assign w_a_mag = w_a_neg ? -bus.SrcA : bus.SrcA;
    assign w_b_mag = w_b_neg ? -bus.SrcB : bus.SrcB;

    // Restoring step: remainder stays below the divisor, so WIDTH bits hold it.
    assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_shift_rem - {1'b0, r_dvs};

    assign w_fix_result = r_is_rem ? (r_neg_r ? -r_rem : r_rem)
                                   : (r_neg_q ? -r_quo : r_quo);

    assign bus.InReady = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.InValid && !bus.Flush) begin
                        if (w_is_div && !w_div_fast) begin
                            r_quo    <= w_a_mag;
                            r_rem    <= '0;
                            r_dvs    <= w_b_mag;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_is_rem <= bus.funct3[1];
                            r_cnt    <= '0;
                            r_state  <= S_DIV;
                        end else begin
                            r_result    <= w_result_now;
                            r_zero      <= (w_result_now == '0);
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    if (bus.Flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (!w_trial[WIDTH]) begin
                            r_rem <= w_trial[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift_rem[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == SW'(WIDTH-1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                default: begin
                    if (!bus.Flush) begin
                        r_result    <= w_fix_result;
                        r_zero      <= (w_fix_result == '0);
                        r_out_valid <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
`else
    logic w_unused;
    assign w_unused    = &{1'b0, bus.Flush, bus.funct7b0, w_is_m};
    assign bus.InReady = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.InValid;
            if (bus.InValid) begin
                r_result <= w_base_result;
                r_zero   <= (w_base_result == '0);
            end
        end
    end
`endif

    assign bus.OutValid  = r_out_valid;
    assign bus.ALUResult = r_result;
    assign bus.Zero      = r_zero;
endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_exec_if #(.WIDTH(WIDTH)) bus ();

    alu_exec #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Decode vectors: {ALUOp, opb5, funct3, funct7b5, expected ALUControl}
    localparam logic [10:0] DEC [14] = '{
        {2'b00, 1'b0, 3'b000, 1'b0, 4'b0000},
        {2'b01, 1'b0, 3'b000, 1'b0, 4'b0001},
        {2'b10, 1'b1, 3'b000, 1'b1, 4'b0001},
        {2'b10, 1'b0, 3'b000, 1'b1, 4'b0000},
        {2'b10, 1'b1, 3'b000, 1'b0, 4'b0000},
        {2'b10, 1'b1, 3'b001, 1'b0, 4'b1000},
        {2'b10, 1'b1, 3'b010, 1'b0, 4'b0101},
        {2'b10, 1'b1, 3'b011, 1'b0, 4'b1001},
        {2'b10, 1'b1, 3'b100, 1'b0, 4'b0100},
        {2'b10, 1'b1, 3'b101, 1'b1, 4'b0111},
        {2'b10, 1'b1, 3'b101, 1'b0, 4'b0110},
        {2'b10, 1'b1, 3'b110, 1'b0, 4'b0011},
        {2'b10, 1'b1, 3'b111, 1'b0, 4'b0010},
        {2'b11, 1'b1, 3'b000, 1'b1, 4'b0001}
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] aluop, input logic op5,
                         input logic [2:0] f3, input logic f7b5, input logic f7b0,
                         input logic [31:0] a, input logic [31:0] b);
        bus.InValid  = v;
        bus.ALUOp    = aluop;
        bus.opb5     = op5;
        bus.funct3   = f3;
        bus.funct7b5 = f7b5;
        bus.funct7b0 = f7b0;
        bus.SrcA     = a;
        bus.SrcB     = b;
    endtask

    // Present one operation at the negedge; expect the result right after the
    // accepting edge (latency 1). Consecutive calls give back-to-back accepts.
    task automatic one_cycle_op(input string tag, input logic [1:0] aluop, input logic op5,
                                input logic [2:0] f3, input logic f7b5, input logic f7b0,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        drive(1'b1, aluop, op5, f3, f7b5, f7b0, a, b);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(bus.OutValid), 32'd1);
        check({tag, "_result"}, bus.ALUResult, exp);
        check({tag, "_zero"}, 32'(bus.Zero), 32'(exp == 32'd0));
    endtask

`ifdef ALU_EXEC_MDU_EN
    task automatic do_div(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int   lat;
        logic ready_low;
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b1, f3, 1'b0, 1'b1, a, b);
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
        lat = 1;
        ready_low = 1'b1;
        while (!bus.OutValid && lat < 100) begin
            if (bus.InReady) ready_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd34);
        check({tag, "_inready_low"}, 32'(ready_low), 32'd1);
        check({tag, "_result"}, bus.ALUResult, exp);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (bus.OutValid) seen = 1'b1;
        end
        check({tag, "_no_outvalid"}, 32'(seen), 32'd0);
    endtask
`endif

    initial begin
        reset     = 1'b1;
        bus.Flush = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_outvalid", 32'(bus.OutValid), 32'd0);
        check("rst_result", bus.ALUResult, 32'd0);
        check("rst_zero", 32'(bus.Zero), 32'd1);
        check("rst_inready", 32'(bus.InReady), 32'd1);

        // Combinational decode
        for (int i = 0; i < 14; i++) begin
            logic [10:0] v;
            v = DEC[i];
            drive(1'b0, v[10:9], v[8], v[7:5], v[4], 1'b0, 32'd0, 32'd0);
            #1;
            check($sformatf("dec%0d", i), 32'(bus.ALUControl), 32'(v[3:0]));
        end

        // Back-to-back base operations
        one_cycle_op("add",  2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        one_cycle_op("sub",  2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 32'd3, 32'd3, 32'd0);
        one_cycle_op("sra",  2'b10, 1'b1, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000);
        one_cycle_op("srl",  2'b10, 1'b1, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000);
        one_cycle_op("sll",  2'b10, 1'b1, 3'b001, 1'b0, 1'b0, 32'd1, 32'h0000_0021, 32'd2);
        one_cycle_op("slt",  2'b10, 1'b1, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1);
        one_cycle_op("sltu", 2'b10, 1'b1, 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        one_cycle_op("xor",  2'b10, 1'b1, 3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        one_cycle_op("or",   2'b10, 1'b1, 3'b110, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        one_cycle_op("and",  2'b10, 1'b1, 3'b111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        one_cycle_op("rsub", 2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 32'd10, 32'd3, 32'd7);

        // Idle cycle: pulse drops, result held
        @(negedge clk);
        bus.InValid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_outvalid", 32'(bus.OutValid), 32'd0);
        check("idle_hold", bus.ALUResult, 32'd7);

`ifdef ALU_EXEC_MDU_EN
        // M op decode reports add
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b1, 3'b001, 1'b0, 1'b1, 32'd0, 32'd0);
        #1;
        check("m_aluctl", 32'(bus.ALUControl), 32'd0);

        one_cycle_op("mul",    2'b10, 1'b1, 3'b000, 1'b0, 1'b1, 32'd7, 32'd6, 32'd42);
        one_cycle_op("mulh",   2'b10, 1'b1, 3'b001, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        one_cycle_op("mulhsu", 2'b10, 1'b1, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        one_cycle_op("mulhu",  2'b10, 1'b1, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Divide fast paths complete in one cycle
        one_cycle_op("divu0",  2'b10, 1'b1, 3'b101, 1'b0, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF);
        one_cycle_op("rem0",   2'b10, 1'b1, 3'b110, 1'b0, 1'b1, 32'd5, 32'd0, 32'd5);
        one_cycle_op("divovf", 2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        one_cycle_op("removf", 2'b10, 1'b1, 3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        check("fast_inready", 32'(bus.InReady), 32'd1);

        // Iterative divides
        do_div("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_div("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_div("divu", 3'b101, 32'd100, 32'd7, 32'd14);
        do_div("remu", 3'b111, 32'd100, 32'd7, 32'd2);

        // Flush 10 cycles into a divide
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b1, 3'b101, 1'b0, 1'b1, 32'd1000, 32'd3);
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.Flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_inready", 32'(bus.InReady), 32'd1);
        check("flush_outvalid", 32'(bus.OutValid), 32'd0);
        check("flush_hold", bus.ALUResult, 32'd2);
        @(negedge clk);
        bus.Flush = 1'b0;
        watch_no_valid("flush", 40);

        // Flush alongside InValid in IDLE suppresses the accept
        @(negedge clk);
        bus.Flush = 1'b1;
        drive(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
        @(posedge clk);
        #1;
        check("flush_idle_outvalid", 32'(bus.OutValid), 32'd0);
        check("flush_idle_hold", bus.ALUResult, 32'd2);
        @(negedge clk);
        bus.Flush = 1'b0;
        bus.InValid = 1'b0;
        one_cycle_op("post_flush_add", 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3);

        // Reset in the middle of a divide
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b1, 3'b101, 1'b0, 1'b1, 32'd1000, 32'd3);
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mdrst_result", bus.ALUResult, 32'd0);
        check("mdrst_zero", 32'(bus.Zero), 32'd1);
        check("mdrst_inready", 32'(bus.InReady), 32'd1);
        watch_no_valid("mdrst", 40);
`else
        // funct7b0 ignored: R-type add with funct7b0 set
        one_cycle_op("f7b0_add", 2'b10, 1'b1, 3'b000, 1'b0, 1'b1, 32'd6, 32'd4, 32'd10);
        check("nomdu_inready", 32'(bus.InReady), 32'd1);
        // Flush has no effect
        @(negedge clk);
        bus.Flush = 1'b1;
        drive(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
        @(posedge clk);
        #1;
        check("nomdu_flush_valid", 32'(bus.OutValid), 32'd1);
        check("nomdu_flush_result", bus.ALUResult, 32'd2);
        check("nomdu_flush_inready", 32'(bus.InReady), 32'd1);
        @(negedge clk);
        bus.Flush = 1'b0;
        bus.InValid = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec.md
# alu_exec

Parametrised execute unit: decodes ALUOp/funct3/funct7 into a 4-bit ALU operation, computes base RV integer results, and, when compiled in, RV M-extension multiply/divide. Base operations and multiplies return in one cycle. Divide/remainder runs as a WIDTH-iteration restoring sequencer behind a valid/ready handshake. Sits in the execute stage in place of the separate ALU decoder + ALU pair; the core stalls while InReady is low.

## Interface
- WIDTH, 32, datapath width; power of two, >= 8.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- Flush  in  1  abandon any in-flight divide; no OutValid for it.
- InValid  in  1  operation presented this cycle.
- InReady  out  1  unit can accept an operation.
- opb5  in  1  opcode bit 5 (1 = R-type).
- funct3  in  3  instruction funct3.
- funct7b5  in  1  funct7 bit 5.
- funct7b0  in  1  funct7 bit 0 (M-extension select).
- ALUOp  in  2  00 add, 01 sub, 10/11 decode by funct fields.
- SrcA, SrcB  in  WIDTH  operands.
- ALUControl  out  4  combinational decode of current inputs.
- OutValid  out  1  one-cycle pulse, ALUResult/Zero valid.
- ALUResult  out  WIDTH  registered result, held until next completion.
- Zero  out  1  registered, ALUResult == 0.

## Operation
- ALUControl: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, srl 0110, sra 0111, sll 1000, sltu 1001. ALUOp 00 -> add, 01 -> sub. Otherwise funct3 000 -> sub if opb5&funct7b5 else add; 001 sll; 010 slt; 011 sltu; 100 xor; 101 sra if funct7b5 else srl; 110 or; 111 and.
- Shifts use SrcB[$clog2(WIDTH)-1:0]; slt/sltu return zero-extended 0/1.
- M op when ALUOp[1] & opb5 & funct7b0: funct3 000 mul (low WIDTH), 001 mulh (s x s high), 010 mulhsu (s x u high), 011 mulhu (u x u high), 100 div, 101 divu, 110 rem, 111 remu. ALUControl reports 0000 for M ops.
- States: IDLE, DIV, FIX.
  - IDLE: InReady=1. Accept on InValid. Base/mul: register result, pulse OutValid next cycle, stay IDLE. Divide: load magnitudes, sign flags, iteration counter=0 -> DIV.
  - Fast-path divides (complete like base ops, never enter DIV): divisor 0 -> div/divu quotient all ones, rem/remu = SrcA. Signed overflow (SrcA = most-negative, SrcB = -1) -> div = SrcA, rem = 0.
  - DIV: InReady=0, one shift-subtract per cycle; after WIDTH iterations -> FIX.
  - FIX: apply signs (quotient negative if operand signs differ, remainder takes dividend sign), register ALUResult, pulse OutValid, -> IDLE. InReady=0 in FIX.
- Flush: in DIV/FIX -> IDLE next cycle, no OutValid, ALUResult unchanged. Flush with InValid in IDLE suppresses the accept.
- reset: state IDLE, ALUResult 0, Zero 1, OutValid 0, counter 0; reset during DIV discards it.

## Timing
- Accept at edge N: base/mul/fast-path -> OutValid high in cycle after edge N (latency 1); back-to-back accepts every cycle allowed.
- Divide accepted at edge N: iterations edges N+1..N+WIDTH, FIX at edge N+WIDTH+1; OutValid high the following cycle (latency WIDTH+2). InReady low from after edge N until FIX completes; next accept earliest at edge N+WIDTH+2.
- ALUControl purely combinational, zero latency.

## Configuration
- ALU_EXEC_MDU_EN defined: M-extension ops, multiplier, divide sequencer (DIV/FIX) present.
- Undefined: funct7b0 ignored, every operation completes in 1 cycle, InReady tied 1, Flush has no effect; no multiplier/divider hardware.

## Test plan
- WIDTH=32, add 5+(-7), sub 3-3, sra 0x80000000>>>4 -> 0xFFFFFFFE, 0 (Zero=1), 0xF8000000, each OutValid one cycle after accept, back-to-back.
- div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; divu 100/7 -> 14; OutValid exactly 34 cycles after accept, InReady low throughout.
- divu 5/0 -> 0xFFFFFFFF, rem 5/0 -> 5, div 0x80000000/-1 -> 0x80000000, rem -> 0; all latency 1.
- mulh 0x80000000 x 0x80000000 -> 0x40000000; mulhsu -1 x 0xFFFFFFFF -> 0xFFFFFFFF; mulhu 0xFFFFFFFF^2 -> 0xFFFFFFFE.
- Flush 10 cycles into a div -> no OutValid, InReady high next cycle, prior ALUResult held; reset mid-div -> ALUResult 0, Zero 1.
- ALU_EXEC_MDU_EN undefined: R-type funct3 000, funct7b0=1, 6+4 -> 10 latency 1, InReady constant 1.
